// File: rtl/bfp_pkg.sv
// -----------------------------------------------------------------------------
// bfp_pkg
// Shared constants and types for the block-floating-point dot-product path.
//   FP16_W        : width of one FP16 element
//   BFP_RES_W     : width of the datapath's final result
//   BFP_BLOCK_LEN : elements per block (equals the SIPO depth)
//   MANT_W/EXP_W  : FP16 mantissa and exponent field widths
//   state_t       : sequencing states of the scheduler
// -----------------------------------------------------------------------------
package bfp_pkg;

  localparam int FP16_W        = 16;
  localparam int BFP_RES_W     = 32;
  localparam int BFP_BLOCK_LEN = 4;
  localparam int MANT_W        = 10;
  localparam int EXP_W         = 5;

  typedef enum logic {
    S_FILL,
    S_WAIT
  } state_t;

endpackage

// File: rtl/bfp_result_fifo.sv
// -----------------------------------------------------------------------------
// bfp_result_fifo
// Small synchronous FIFO holding tagged dot-product results.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   clear      : synchronous empty request (wins over push/pop)
//   push/pushData : write one entry (caller guarantees a free slot)
//   pop        : drop the head entry; ignored when empty
//   popData    : head entry, read straight from storage so it stays stable
//   full/empty/count : occupancy status
// -----------------------------------------------------------------------------
module bfp_result_fifo #(
  parameter  int WIDTH = 40,
  parameter  int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] pushData,
  input  logic             pop,
  output logic [WIDTH-1:0] popData,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic [CNT_W-1:0] r_count;
  logic             w_doPop;

  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_doPop = pop && (r_count != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else if (clear) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (push)    r_wrPtr <= nextPtr(r_wrPtr);
      if (w_doPop) r_rdPtr <= nextPtr(r_rdPtr);
      r_count <= r_count + CNT_W'(push) - CNT_W'(w_doPop);
    end
  end

  // Storage carries no reset; the head is only meaningful while non-empty.
  always_ff @(posedge clk) begin
    if (push && !clear) r_mem[r_wrPtr] <= pushData;
  end

  assign popData = r_mem[r_rdPtr];
  assign count   = r_count;
  assign full    = (r_count == CNT_W'(DEPTH));
  assign empty   = (r_count == '0);

  // The scheduler reserves a slot before starting a block, so a push can
  // never meet a full FIFO.
  assert property (@(posedge clk) disable iff (!rst_n) !(push && full));

endmodule

// File: rtl/bfp_dot_scheduler.sv
// -----------------------------------------------------------------------------
// bfp_dot_scheduler
// Sequences FP16 element pairs into the block-floating-point dot-product
// datapath, waits its latency and queues the tagged results.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   flush          : synchronous abort; drops partial block and queued results
//   in_valid/in_ready, in_a/in_b : element pair stream
//   dp_v1/dp_v2/dp_enable        : datapath SIPO inputs and shift enable
//   dp_result                    : datapath final result
//   out_valid/out_ready, out_data/out_idx : result stream with block index
//   busy           : block partially filled or awaiting capture
// -----------------------------------------------------------------------------
module bfp_dot_scheduler
  import bfp_pkg::*;
#(
  parameter int IN_W       = FP16_W,
  parameter int OUT_W      = BFP_RES_W,
  parameter int BLOCK_LEN  = BFP_BLOCK_LEN,
  parameter int DP_LATENCY = 1,
  parameter int OUT_DEPTH  = 2,
  parameter int IDX_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_a,
  input  logic [IN_W-1:0]  in_b,
  output logic [IN_W-1:0]  dp_v1,
  output logic [IN_W-1:0]  dp_v2,
  output logic             dp_enable,
  input  logic [OUT_W-1:0] dp_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [IDX_W-1:0] out_idx,
  output logic             busy
);

  localparam int ELEM_W = $clog2(BLOCK_LEN + 1);
  localparam int WAIT_W = $clog2(DP_LATENCY + 1);
  localparam int CNT_W  = $clog2(OUT_DEPTH + 1);
  localparam int ENT_W  = IDX_W + OUT_W;

  state_t            r_state;
  logic [ELEM_W-1:0] r_elemCnt;
  logic [WAIT_W-1:0] r_waitCnt;
  logic [IDX_W-1:0]  r_blkIdx;

  state_t            w_nextState;
  logic [ELEM_W-1:0] w_nextElemCnt;
  logic [WAIT_W-1:0] w_nextWaitCnt;
  logic [IDX_W-1:0]  w_nextBlkIdx;
  logic              w_inReady;
  logic              w_push;
  logic              w_fifoFull;
  logic              w_fifoEmpty;
  logic [CNT_W-1:0]  w_fifoCount;
  logic [ENT_W-1:0]  w_popData;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_FILL;
      r_elemCnt <= '0;
      r_waitCnt <= '0;
      r_blkIdx  <= '0;
    end else begin
      r_state   <= w_nextState;
      r_elemCnt <= w_nextElemCnt;
      r_waitCnt <= w_nextWaitCnt;
      r_blkIdx  <= w_nextBlkIdx;
    end
  end

  // A new block may only start when a FIFO slot is free; once started, the
  // slot stays reserved because pops can only free more space.
  always_comb begin
    w_nextState   = r_state;
    w_nextElemCnt = r_elemCnt;
    w_nextWaitCnt = r_waitCnt;
    w_nextBlkIdx  = r_blkIdx;
    w_inReady     = 1'b0;
    w_push        = 1'b0;
    if (flush) begin
      w_nextState   = S_FILL;
      w_nextElemCnt = '0;
      w_nextWaitCnt = '0;
      w_nextBlkIdx  = '0;
    end else begin
      case (r_state)
        S_FILL: begin
          w_inReady = (r_elemCnt != '0) || !w_fifoFull;
          if (in_valid && w_inReady) begin
            if (r_elemCnt == ELEM_W'(BLOCK_LEN - 1)) begin
              w_nextElemCnt = '0;
              w_nextWaitCnt = WAIT_W'(DP_LATENCY - 1);
              w_nextState   = S_WAIT;
            end else begin
              w_nextElemCnt = r_elemCnt + ELEM_W'(1);
            end
          end
        end
        S_WAIT: begin
          // The final wait edge is also the capture edge.
          if (r_waitCnt != '0) begin
            w_nextWaitCnt = r_waitCnt - WAIT_W'(1);
          end else begin
            w_push       = 1'b1;
            w_nextBlkIdx = r_blkIdx + IDX_W'(1);
            w_nextState  = S_FILL;
          end
        end
        default: w_nextState = S_FILL;
      endcase
    end
  end

  // Handshake is gated by rst_n so nothing is accepted while reset is held.
  assign in_ready  = rst_n && w_inReady;
  assign dp_enable = in_valid && in_ready;
  assign dp_v1     = in_a;
  assign dp_v2     = in_b;
  assign busy      = (r_state == S_WAIT) || (r_elemCnt != '0);

  bfp_result_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (OUT_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (flush),
    .push     (w_push),
    .pushData ({r_blkIdx, dp_result}),
    .pop      (out_ready),
    .popData  (w_popData),
    .full     (w_fifoFull),
    .empty    (w_fifoEmpty),
    .count    (w_fifoCount)
  );

  assign out_valid = !w_fifoEmpty;
  assign out_data  = w_popData[OUT_W-1:0];
  assign out_idx   = w_popData[OUT_W +: IDX_W];

  assert property (@(posedge clk) disable iff (!rst_n)
                   w_fifoCount <= CNT_W'(OUT_DEPTH));

endmodule

// File: doc/bfp_dot_scheduler.md
Name: bfp_dot_scheduler

Overview:
- Sequencing controller for the block-floating-point dot-product datapath: two SIPO_4 shifters feeding normalization, adder_tree and renormalization.
- Accepts a valid/ready stream of FP16 element pairs and drives the shared datapath `enable` for exactly BLOCK_LEN elements per block.
- Waits the datapath latency, then captures the 32-bit result into a small output FIFO, tagged with a block index.
- Forbids overlap between blocks: the SIPO would shift a new block over one still being evaluated.

Parameters:
- IN_W, 16, FP16 element width (v1/v2 width)
- OUT_W, 32, datapath result width
- BLOCK_LEN, 4, elements per block; must match SIPO depth
- DP_LATENCY, 1, rising edges from the edge accepting the last element to the capture edge (>=1)
- OUT_DEPTH, 2, output FIFO entries (>=1)
- IDX_W, 8, block index width

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous abort/clear
- in_valid  in  1  element pair valid
- in_ready  out  1  element pair accepted when in_valid && in_ready
- in_a  in  IN_W  vector-1 element
- in_b  in  IN_W  vector-2 element
- dp_v1  out  IN_W  to datapath v1 (= in_a)
- dp_v2  out  IN_W  to datapath v2 (= in_b)
- dp_enable  out  1  datapath SIPO shift enable
- dp_result  in  OUT_W  datapath final_result
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer pop
- out_data  out  OUT_W  FIFO head result
- out_idx  out  IDX_W  block index of head
- busy  out  1  block partially filled or awaiting capture

Behaviour:
- Reset (rst_n low, async):
  - state=FILL, elem_cnt=0, wait_cnt=0, FIFO empty, blk_idx=0.
  - out_valid=0, busy=0; in_ready and dp_enable forced 0 while rst_n is low.
- FSM states:
  - FILL: accepts elements.
  - WAIT: counts latency.
  - Capture happens on the final WAIT edge; there is no separate capture cycle.
- FILL:
  - in_ready = (elem_cnt!=0) || (fifo_count<OUT_DEPTH).
  - A block starts only if a FIFO slot exists. Mid-block, space is guaranteed, because pops only free slots.
  - dp_enable = in_valid && in_ready (combinational). dp_v1/dp_v2 are combinational pass-throughs of in_a/in_b.
  - On accept: elem_cnt++.
  - On accept with elem_cnt==BLOCK_LEN-1: elem_cnt<=0, wait_cnt<=DP_LATENCY-1, state<=WAIT.
  - in_valid low: hold; no timeout.
- WAIT:
  - in_ready=0, dp_enable=0.
  - wait_cnt!=0: decrement.
  - wait_cnt==0: push {blk_idx, dp_result} into FIFO, blk_idx++ (wraps 2^IDX_W-1 -> 0), state<=FILL.
- Latency and throughput:
  - With DP_LATENCY=1, out_valid rises one edge after the edge accepting element 4.
  - Peak throughput is BLOCK_LEN elements per BLOCK_LEN+DP_LATENCY cycles.
- busy = (state==WAIT) || (elem_cnt!=0).
- Output FIFO:
  - out_valid = fifo_count!=0; pop on out_valid && out_ready.
  - Simultaneous push and pop: count unchanged, ordering preserved.
  - Push into a full FIFO is impossible by construction; an assertion is required.
  - Pop when empty is ignored.
  - out_data/out_idx are undefined-but-stable (registered) when empty.
- flush (sync, highest priority after reset):
  - Clears elem_cnt, wait_cnt, FIFO, blk_idx; state<=FILL.
  - in_ready=0 and dp_enable=0 in the flush cycle.
  - A partially shifted SIPO is not cleared; the next full block overwrites it.
- Reset or flush mid-WAIT: pending capture is dropped; no output is produced.

Decomposition:
- Shared package bfp_pkg:
  - FP16_W=16, BFP_RES_W=32, BFP_BLOCK_LEN=4, MANT_W=10, EXP_W=5.
  - State enum {S_FILL, S_WAIT}.
- One sub-module: bfp_result_fifo.
  - Parameterised width/depth, synchronous FIFO.
  - Ports push/pop/full/empty/count, same clk/rst_n.
- FSM and counters stay in bfp_dot_scheduler.

Test Plan:
- Basic block:
  - Stimulus: reset; 4 consecutive pairs (a=16'h3C00, b=16'h4000); stub dp_result=32'h41000000.
  - Response: dp_enable high exactly 4 cycles; out_valid one edge after the 4th accept; out_data=32'h41000000, out_idx=0.
- Gapped input:
  - Stimulus: in_valid toggles 1,0,1,0,...
  - Response: dp_enable only on accepted cycles; capture after the 4th accept, not the 4th cycle.
- Backpressure:
  - Stimulus: out_ready=0, DP_LATENCY=3, 3 blocks offered.
  - Response: 2 results held, idx 0 and 1; in_ready=0 at start of block 3; release out_ready → block 3 accepted, idx=2, order preserved.
- Simultaneous push/pop:
  - Stimulus: FIFO holding 1 entry; capture edge coincides with pop.
  - Response: fifo_count stays 1; head switches to the new result.
- Index wrap:
  - Stimulus: IDX_W=2, 5 blocks.
  - Response: out_idx sequence 0,1,2,3,0.
- Abort:
  - Stimulus: flush after 2 accepted elements, then reset asserted during a WAIT state.
  - Response: elem_cnt=0, busy=0, no output produced; next full block yields idx=0.
